// File: rtl/segled_scan_ctrl.sv
// Multiplexed seven-segment scan controller: hex decode, dp/blink, leading-zero
// suppression, dead time between digits and frame-synchronous double buffering.
module segled_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 16384,
   parameter int BLANK_CYCLES   = 64,
   parameter int BLINK_DIV      = 25000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    load_ack,
   output logic                    frame_done
);

   localparam int SLOT_W  = $clog2(SCAN_DIV);
   localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
   localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SLOT_W-1:0]       slot_cnt_reg, slot_cnt_next;
   logic [DIG_W-1:0]        dig_idx_reg, dig_idx_next;
   logic [BLINK_W-1:0]      blink_cnt_reg, blink_cnt_next;
   logic                    blink_ph_reg, blink_ph_next;

   logic [4*NUM_DIGITS-1:0] pend_data_reg, act_data_reg, act_data_next;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg, act_dp_next;
   logic [NUM_DIGITS-1:0]   pend_blink_reg, act_blink_reg, act_blink_next;
   logic                    pend_valid_reg;

   logic                    slot_wrap, boundary, commit;
   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS:0]     zero_above;
   logic [NUM_DIGITS-1:0]   lz_mask;

   logic [6:0]              seg_on;
   logic                    dp_on, dark, suppress;
   logic [NUM_DIGITS-1:0]   dig_on;

   logic [6:0]              seg_reg, seg_next;
   logic                    seg_dp_reg, seg_dp_next;
   logic [NUM_DIGITS-1:0]   dig_sel_reg, dig_sel_next;
   logic                    load_ack_reg, frame_done_reg;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_wrap = (slot_cnt_reg == SLOT_LAST);
      boundary  = enable && slot_wrap && (dig_idx_reg == DIG_LAST);
      commit    = boundary && pend_valid_reg;

      slot_cnt_next = '0;
      dig_idx_next  = '0;
      if (enable) begin
         slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + SLOT_W'(1);
         dig_idx_next  = dig_idx_reg;
         if (slot_wrap)
            dig_idx_next = (dig_idx_reg == DIG_LAST) ? '0 : dig_idx_reg + DIG_W'(1);
      end

      blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
      blink_ph_next  = blink_ph_reg;
      if (blink_cnt_reg == BLINK_LAST) begin
         blink_cnt_next = '0;
         blink_ph_next  = ~blink_ph_reg;
      end

      act_data_next  = commit ? pend_data_reg  : act_data_reg;
      act_dp_next    = commit ? pend_dp_reg    : act_dp_reg;
      act_blink_next = commit ? pend_blink_reg : act_blink_reg;
   end

   // zero_above[i] is set when nibbles i..NUM_DIGITS-1 of the next active word are all zero
   assign zero_above[NUM_DIGITS] = 1'b1;
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]        = act_data_next[4*gi +: 4];
         assign zero_above[gi] = (nib[gi] == 4'h0) && zero_above[gi+1];
         if (gi == 0) begin : g_first
            assign lz_mask[gi] = 1'b0;
         end else begin : g_upper
            assign lz_mask[gi] = zero_above[gi];
         end
      end
   endgenerate

   // Outputs are decoded from next-state values so the registered pins line up with the state
   always_comb begin
      dark     = blink_ph_next & act_blink_next[dig_idx_next];
      suppress = lz_blank & lz_mask[dig_idx_next];
      seg_on   = '0;
      dp_on    = 1'b0;
      dig_on   = '0;
      if (enable) begin
         if (!(dark || suppress))
            seg_on = hex7(nib[dig_idx_next]);
         dp_on = act_dp_next[dig_idx_next] & ~dark;
         if (slot_cnt_next >= BLANK_END)
            dig_on = NUM_DIGITS'(1) << dig_idx_next;
      end
      seg_next     = seg_on ^ {7{SEG_ACTIVE_LOW}};
      seg_dp_next  = dp_on ^ SEG_ACTIVE_LOW;
      dig_sel_next = dig_on ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         slot_cnt_reg   <= '0;
         dig_idx_reg    <= '0;
         blink_cnt_reg  <= '0;
         blink_ph_reg   <= 1'b0;
         pend_data_reg  <= '0;
         pend_dp_reg    <= '0;
         pend_blink_reg <= '0;
         pend_valid_reg <= 1'b0;
         act_data_reg   <= '0;
         act_dp_reg     <= '0;
         act_blink_reg  <= '0;
         seg_reg        <= {7{SEG_ACTIVE_LOW}};
         seg_dp_reg     <= SEG_ACTIVE_LOW;
         dig_sel_reg    <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
         load_ack_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         slot_cnt_reg   <= slot_cnt_next;
         dig_idx_reg    <= dig_idx_next;
         blink_cnt_reg  <= blink_cnt_next;
         blink_ph_reg   <= blink_ph_next;
         act_data_reg   <= act_data_next;
         act_dp_reg     <= act_dp_next;
         act_blink_reg  <= act_blink_next;
         // A load in the boundary cycle refills pending after the old contents commit
         if (load) begin
            pend_data_reg  <= data_in;
            pend_dp_reg    <= dp_in;
            pend_blink_reg <= blink_en;
            pend_valid_reg <= 1'b1;
         end else if (commit) begin
            pend_valid_reg <= 1'b0;
         end
         seg_reg        <= seg_next;
         seg_dp_reg     <= seg_dp_next;
         dig_sel_reg    <= dig_sel_next;
         load_ack_reg   <= commit;
         frame_done_reg <= boundary;
      end
   end

   assign seg        = seg_reg;
   assign seg_dp     = seg_dp_reg;
   assign dig_sel    = dig_sel_reg;
   assign load_ack   = load_ack_reg;
   assign frame_done = frame_done_reg;

endmodule
